lcd_cmd_sched: RTL and testbench

- Command scheduler in front of the LCD image-processing controller. It shares that controller's single cmd/cmd_valid port between two requesters: a host port and an on-chip script ROM player.
- Arbitrates round-robin and issues one command per slot, and only when the controller is not busy.
- Treats WRITE (cmd 0) as terminal: after issuing it, waits for the controller's done, then reports completion.

---
 rtl/lcd_pkg.sv | 41 ++++
 rtl/lcd_script_fetch.sv | 55 +++++
 rtl/lcd_cmd_sched.sv | 135 +++++++++++++
 tb/tb_lcd_cmd_sched.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command scheduler.
// Includes command codes, scheduler states, requester ids and the round-robin pick.
package lcd_pkg;

    localparam logic [2:0] CMD_WRITE = 3'd0;
    localparam logic [2:0] CMD_UP    = 3'd1;
    localparam logic [2:0] CMD_DOWN  = 3'd2;
    localparam logic [2:0] CMD_LEFT  = 3'd3;
    localparam logic [2:0] CMD_RIGHT = 3'd4;
    localparam logic [2:0] CMD_AVG   = 3'd5;
    localparam logic [2:0] CMD_MIRX  = 3'd6;
    localparam logic [2:0] CMD_MIRY  = 3'd7;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARB   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_GAPW  = 3'd3,
        ST_WAITW = 3'd4,
        ST_FIN   = 3'd5
    } sched_state_e;

    typedef enum logic {
        REQ_HOST   = 1'b0,
        REQ_SCRIPT = 1'b1
    } req_e;

    // On a tie the requester that was not served last wins.
    function automatic req_e pick_winner(input logic h, input logic s, input req_e last_srv);
        req_e w;
        if (h && s) begin
            w = (last_srv == REQ_HOST) ? REQ_SCRIPT : REQ_HOST;
        end else if (s) begin
            w = REQ_SCRIPT;
        end else begin
            w = REQ_HOST;
        end
        return w;
    endfunction

endpackage

// File: rtl/lcd_script_fetch.sv
// Script ROM player: address counter, one-entry command buffer and last-entry handling.
// The buffer data is the synchronous ROM output itself, which stays stable because crom_a only moves on consume.
module lcd_script_fetch
    import lcd_pkg::*;
#(
    parameter int CROM_AW = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_start,
    input  logic               halt,
    input  logic               consume,
    output logic [CROM_AW-1:0] crom_a,
    input  logic [3:0]         crom_q,
    output logic               s_active,
    output logic               s_vld,
    output logic [2:0]         s_cmd
);

    logic fetch_pend;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crom_a     <= '0;
            s_active   <= 1'b0;
            s_vld      <= 1'b0;
            fetch_pend <= 1'b0;
        end else if (halt) begin
            s_active   <= 1'b0;
            s_vld      <= 1'b0;
            fetch_pend <= 1'b0;
        end else if (!s_active) begin
            if (s_start) begin
                s_active   <= 1'b1;
                crom_a     <= '0;
                fetch_pend <= 1'b1;
            end
        end else if (consume && s_vld) begin
            s_vld <= 1'b0;
            if (crom_q[3]) begin
                s_active <= 1'b0;
            end else begin
                // Wraps naturally at 2^CROM_AW; a script without a last marker loops forever.
                crom_a     <= crom_a + 1'b1;
                fetch_pend <= 1'b1;
            end
        end else if (fetch_pend) begin
            s_vld      <= 1'b1;
            fetch_pend <= 1'b0;
        end
    end

    assign s_cmd = crom_q[2:0];

endmodule

// File: rtl/lcd_cmd_sched.sv
// Shares the LCD controller command port between the host and the script player.
// Round-robin arbitration, one command per slot, WRITE is terminal until reset.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_INIT  | waiting for the controller to finish its image load
//   ST_ARB   | picking the next requester while the controller is idle
//   ST_ISSUE | strobe cycle: lcd_cmd_valid high, grant / consume
//   ST_GAPW  | forced idle cycles after a non-write command
//   ST_WAITW | WRITE issued, waiting for lcd_done
//   ST_FIN   | write-out complete, nothing more is issued
module lcd_cmd_sched
    import lcd_pkg::*;
#(
    parameter int CROM_AW = 5,
    parameter int GAP     = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               h_req,
    input  logic [2:0]         h_cmd,
    output logic               h_gnt,
    input  logic               s_start,
    output logic [CROM_AW-1:0] crom_a,
    input  logic [3:0]         crom_q,
    output logic               s_active,
    output logic [2:0]         lcd_cmd,
    output logic               lcd_cmd_valid,
    input  logic               lcd_busy,
    input  logic               lcd_done,
    output logic [7:0]         issued_cnt,
    output logic               sched_done
);

    // GAP cycles of idle are counted down from GAP-1 to zero.
    localparam logic [1:0] GAP_LOAD = 2'(GAP - 1);

    sched_state_e state;
    req_e         last_srv;
    req_e         win_src;
    req_e         pick;
    logic [1:0]   gap_cnt;
    logic         s_vld;
    logic [2:0]   s_cmd;
    logic         s_consume;
    logic         fetch_halt;

    assign s_consume  = (state == ST_ISSUE) && (win_src == REQ_SCRIPT);
    assign fetch_halt = (state == ST_FIN);

    always_comb begin
        pick = pick_winner(h_req, s_vld, last_srv);
    end

    lcd_script_fetch #(
        .CROM_AW (CROM_AW)
    ) u_fetch (
        .clk      (clk),
        .reset    (reset),
        .s_start  (s_start),
        .halt     (fetch_halt),
        .consume  (s_consume),
        .crom_a   (crom_a),
        .crom_q   (crom_q),
        .s_active (s_active),
        .s_vld    (s_vld),
        .s_cmd    (s_cmd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_INIT;
            h_gnt         <= 1'b0;
            lcd_cmd_valid <= 1'b0;
            lcd_cmd       <= CMD_WRITE;
            issued_cnt    <= 8'd0;
            sched_done    <= 1'b0;
            last_srv      <= REQ_HOST;
            win_src       <= REQ_HOST;
            gap_cnt       <= 2'd0;
        end else begin
            h_gnt         <= 1'b0;
            lcd_cmd_valid <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (!lcd_busy) begin
                        state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    // Strobe, grant and count are registered here so they appear during ST_ISSUE.
                    if (!lcd_busy && (h_req || s_vld)) begin
                        win_src       <= pick;
                        last_srv      <= pick;
                        lcd_cmd       <= (pick == REQ_HOST) ? h_cmd : s_cmd;
                        lcd_cmd_valid <= 1'b1;
                        h_gnt         <= (pick == REQ_HOST);
                        if (issued_cnt != 8'hFF) begin
                            issued_cnt <= issued_cnt + 8'd1;
                        end
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (lcd_cmd == CMD_WRITE) begin
                        state <= ST_WAITW;
                    end else begin
                        gap_cnt <= GAP_LOAD;
                        state   <= ST_GAPW;
                    end
                end
                ST_GAPW: begin
                    if (gap_cnt == 2'd0) begin
                        state <= ST_ARB;
                    end else begin
                        gap_cnt <= gap_cnt - 2'd1;
                    end
                end
                ST_WAITW: begin
                    if (lcd_done) begin
                        sched_done <= 1'b1;
                        state      <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    state <= ST_FIN;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Directed and randomized checks of lcd_cmd_sched against a queue-based ordering model.
module tb_lcd_cmd_sched;

    localparam int CROM_AW = 5;
    localparam int GAP     = 1;
    localparam int SPACING = GAP + 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               h_req;
    logic [2:0]         h_cmd;
    logic               h_gnt;
    logic               s_start;
    logic [CROM_AW-1:0] crom_a;
    logic [3:0]         crom_q;
    logic               s_active;
    logic [2:0]         lcd_cmd;
    logic               lcd_cmd_valid;
    logic               lcd_busy;
    logic               lcd_done;
    logic [7:0]         issued_cnt;
    logic               sched_done;

    typedef struct {
        int         cyc;
        logic [2:0] cmd;
        logic       gnt;
    } strobe_t;

    strobe_t    sq[$];
    logic [2:0] hq[$];
    logic [2:0] hl[$];
    logic [2:0] sl[$];
    logic [3:0] rom [0:31];
    bit         host_en;
    int         cyc;
    int         gnt_bad;
    int         n_assert;
    int         n_fail;

    lcd_cmd_sched #(
        .CROM_AW (CROM_AW),
        .GAP     (GAP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .h_req         (h_req),
        .h_cmd         (h_cmd),
        .h_gnt         (h_gnt),
        .s_start       (s_start),
        .crom_a        (crom_a),
        .crom_q        (crom_q),
        .s_active      (s_active),
        .lcd_cmd       (lcd_cmd),
        .lcd_cmd_valid (lcd_cmd_valid),
        .lcd_busy      (lcd_busy),
        .lcd_done      (lcd_done),
        .issued_cnt    (issued_cnt),
        .sched_done    (sched_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) crom_q <= rom[crom_a];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, then update the host requester.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (reset === 1'b1 && lcd_cmd_valid === 1'b1) sq.push_back('{cyc, lcd_cmd, h_gnt});
        if (h_gnt === 1'b1 && lcd_cmd_valid !== 1'b1) gnt_bad++;
        if (h_gnt === 1'b1 && hq.size() > 0) void'(hq.pop_front());
        if (host_en && hq.size() > 0) begin
            h_req = 1'b1;
            h_cmd = hq[0];
        end else begin
            h_req = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        s_start  = 1'b0;
        lcd_done = 1'b0;
        host_en  = 1'b0;
        hq.delete();
        step();
        step();
        sq.delete();
        reset = 1'b1;
    endtask

    task automatic pulse_start();
        s_start = 1'b1;
        step();
        s_start = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        for (int k = 0; k < budget && sq.size() < n; k++) step();
        check("strobe_count", sq.size(), n);
    endtask

    task automatic wait_write(input int budget);
        int found;
        found = 0;
        for (int k = 0; k < budget; k++) begin
            step();
            if (sq.size() > 0 && sq[sq.size()-1].cmd == 3'd0 && sq[sq.size()-1].gnt == 1'b1) begin
                found = 1;
                break;
            end
        end
        check("host_write_issued", found, 1);
    endtask

    // Reference: alternate on ties starting with the one not served last (host after reset),
    // otherwise serve whoever still has work.
    task automatic run_contention();
        logic [2:0] exp_q[$];
        logic       exp_g[$];
        logic       last_script;
        int         i;
        int         j;
        int         bad;
        int         total;
        lcd_busy = 1'b1;
        do_reset();
        for (int k = 0; k < 32; k++) rom[k] = 4'h0;
        for (int k = 0; k < sl.size(); k++) rom[k] = {(k == sl.size() - 1), sl[k]};
        pulse_start();
        foreach (hl[k]) hq.push_back(hl[k]);
        host_en = 1;
        repeat (4) step();
        lcd_busy = 1'b0;
        last_script = 1'b0;
        i = 0;
        j = 0;
        while (i < hl.size() || j < sl.size()) begin
            if (j < sl.size() && (i >= hl.size() || !last_script)) begin
                exp_q.push_back(sl[j]);
                exp_g.push_back(1'b0);
                j++;
                last_script = 1'b1;
            end else begin
                exp_q.push_back(hl[i]);
                exp_g.push_back(1'b1);
                i++;
                last_script = 1'b0;
            end
        end
        total = exp_q.size();
        wait_strobes(total, total * SPACING + 20);
        bad = 0;
        for (int k = 0; k < total; k++) begin
            if (sq[k].cmd !== exp_q[k] || sq[k].gnt !== exp_g[k]) bad++;
            if (k > 0 && sq[k].cyc - sq[k-1].cyc != SPACING) bad++;
        end
        check("contention_order", bad, 0);
        check("contention_cnt", 32'(issued_cnt), total);
        repeat (3) step();
        check("contention_s_active_off", 32'(s_active), 0);
        check("lcd_cmd_hold", 32'(lcd_cmd), 32'(exp_q[total-1]));
    endtask

    initial begin
        int         kfall;
        int         n;
        int         bad;
        logic [2:0] exp_s [4];
        logic [2:0] sat [$];

        reset = 1'b0; h_req = 1'b0; h_cmd = 3'd0; s_start = 1'b0;
        lcd_busy = 1'b1; lcd_done = 1'b0; host_en = 0;
        cyc = 0; gnt_bad = 0; n_assert = 0; n_fail = 0;
        for (int k = 0; k < 32; k++) rom[k] = 4'h0;

        repeat (3) step();
        check("rst_h_gnt", 32'(h_gnt), 0);
        check("rst_valid", 32'(lcd_cmd_valid), 0);
        check("rst_lcd_cmd", 32'(lcd_cmd), 0);
        check("rst_crom_a", 32'(crom_a), 0);
        check("rst_s_active", 32'(s_active), 0);
        check("rst_issued_cnt", 32'(issued_cnt), 0);
        check("rst_sched_done", 32'(sched_done), 0);

        // Bring-up: image load holds the controller busy.
        hq.push_back(3'd4);
        host_en = 1;
        reset = 1'b1;
        repeat (66) step();
        check("bringup_no_strobe_busy", sq.size(), 0);
        lcd_busy = 1'b0;
        kfall = cyc;
        wait_strobes(1, 10);
        check("bringup_latency", sq[0].cyc - kfall, 2);
        check("bringup_cmd", 32'(sq[0].cmd), 4);
        check("bringup_gnt", 32'(sq[0].gnt), 1);
        check("bringup_cnt", 32'(issued_cnt), 1);

        // Script only, ending with a WRITE.
        lcd_busy = 1'b0;
        do_reset();
        rom[0] = 4'h1; rom[1] = 4'h3; rom[2] = 4'h5; rom[3] = 4'h8;
        exp_s[0] = 3'd1; exp_s[1] = 3'd3; exp_s[2] = 3'd5; exp_s[3] = 3'd0;
        pulse_start();
        check("script_active", 32'(s_active), 1);
        wait_strobes(4, 40);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (sq[k].cmd !== exp_s[k] || sq[k].gnt !== 1'b0) bad++;
            if (k > 0 && sq[k].cyc - sq[k-1].cyc != SPACING) bad++;
        end
        check("script_seq", bad, 0);
        check("script_active_at_last", 32'(s_active), 1);
        step();
        check("script_active_drop", 32'(s_active), 0);
        check("script_done_pre", 32'(sched_done), 0);
        lcd_done = 1'b1;
        step();
        lcd_done = 1'b0;
        check("script_sched_done", 32'(sched_done), 1);
        check("script_cnt", 32'(issued_cnt), 4);

        // Contention: the fixed pattern, then random ones.
        hl = '{3'd2, 3'd2, 3'd2};
        sl = '{3'd6, 3'd7, 3'd6};
        run_contention();
        repeat (2) begin
            hl.delete();
            sl.delete();
            n = $urandom_range(6, 2);
            for (int k = 0; k < n; k++) hl.push_back(3'($urandom_range(7, 1)));
            n = $urandom_range(6, 2);
            for (int k = 0; k < n; k++) sl.push_back(3'($urandom_range(7, 1)));
            run_contention();
        end

        // Endless script wrapping the ROM, then a host WRITE blocks everything.
        lcd_busy = 1'b0;
        do_reset();
        for (int k = 0; k < 32; k++) rom[k] = {1'b0, 3'($urandom_range(7, 1))};
        pulse_start();
        wait_strobes(36, 36 * SPACING + 20);
        bad = 0;
        for (int k = 0; k < 36; k++) begin
            if (sq[k].cmd !== rom[k % 32][2:0]) bad++;
            if (k > 0 && sq[k].cyc - sq[k-1].cyc != SPACING) bad++;
        end
        check("script_wrap_seq", bad, 0);
        hq.push_back(3'd0);
        host_en = 1;
        wait_write(20);
        n = sq.size();
        hq.push_back(3'd3);
        repeat (30) step();
        check("waitw_no_strobe", sq.size(), n);
        check("waitw_s_active", 32'(s_active), 1);
        check("waitw_done_pre", 32'(sched_done), 0);
        lcd_done = 1'b1;
        step();
        lcd_done = 1'b0;
        check("waitw_sched_done", 32'(sched_done), 1);
        repeat (20) step();
        check("fin_no_strobe", sq.size(), n);
        check("fin_s_active", 32'(s_active), 0);
        check("fin_cnt", 32'(issued_cnt), n);

        // Asynchronous reset in the middle of ST_WAITW.
        lcd_busy = 1'b0;
        do_reset();
        pulse_start();
        wait_strobes(2, 20);
        hq.push_back(3'd0);
        host_en = 1;
        wait_write(20);
        repeat (3) step();
        #2 reset = 1'b0;
        #1;
        check("arst_valid", 32'(lcd_cmd_valid), 0);
        check("arst_h_gnt", 32'(h_gnt), 0);
        check("arst_s_active", 32'(s_active), 0);
        check("arst_crom_a", 32'(crom_a), 0);
        check("arst_issued_cnt", 32'(issued_cnt), 0);
        check("arst_lcd_cmd", 32'(lcd_cmd), 0);
        lcd_busy = 1'b1;
        hq.delete();
        hq.push_back(3'd6);
        step();
        sq.delete();
        reset = 1'b1;
        repeat (15) step();
        check("arst_init_hold", sq.size(), 0);
        lcd_busy = 1'b0;
        kfall = cyc;
        wait_strobes(1, 10);
        check("arst_restart_latency", sq[0].cyc - kfall, 2);
        check("arst_restart_cmd", 32'(sq[0].cmd), 6);

        // Saturation of the issue counter.
        lcd_busy = 1'b0;
        do_reset();
        for (int k = 0; k < 300; k++) sat.push_back(3'($urandom_range(7, 1)));
        foreach (sat[k]) hq.push_back(sat[k]);
        host_en = 1;
        wait_strobes(200, 200 * SPACING + 20);
        check("sat_cnt_200", 32'(issued_cnt), 200);
        wait_strobes(300, 100 * SPACING + 20);
        check("sat_cnt_300", 32'(issued_cnt), 255);
        bad = 0;
        for (int k = 0; k < 300; k++) if (sq[k].cmd !== sat[k]) bad++;
        check("sat_cmd_order", bad, 0);

        check("gnt_without_strobe", gnt_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
